dcache_msi: RTL and testbench

Per-core L1 data cache: direct-mapped, write-back, one-word blocks, MSI-coherent. It sits between a core's datapath memory port and that core's slot on the shared coherency bus. It services loads and stores on hits. On a miss it issues bus reads and writes. It answers snoops from the coherency controller by supplying Modified data and downgrading or invalidating lines. On halt it flushes all dirty lines.

---
 rtl/dcache_msi_if.sv | 22 ++
 rtl/dcache_msi.sv | 192 +++++++++++++++++++
 tb/tb_dcache_msi.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_msi_if.sv
// Datapath and coherency-bus signals of one L1 data cache slot.
// master: the cache. slave: the datapath/bus/coherency environment.
interface dcache_msi_if;
  logic        halt, dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        dhit, flushed;
  logic        dREN, dWEN, dwait;
  logic [31:0] daddr, dstore, dload;
  logic        ccwrite, cctrans, ccwait, ccinv;
  logic [31:0] ccsnoopaddr;

  modport master (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
           ccwait, ccinv, ccsnoopaddr,
    output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore, ccwrite, cctrans
  );
  modport slave (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
           ccwait, ccinv, ccsnoopaddr,
    input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore, ccwrite, cctrans
  );
endinterface

// File: rtl/dcache_msi.sv
// Direct-mapped, write-back, one-word-block L1 data cache with MSI coherence.
// Line state: I = !valid, S = valid & !dirty, M = valid & dirty.
module dcache_msi #(
  parameter int SETS = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  dcache_msi_if.master cif
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic [2:0] {IDLE, WB, FETCH, SNOOP, SNOOP_WB, FLUSH, DONE} state_t;

  state_t          state_q, state_d, saved_q, saved_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [SETS-1:0] valid_q, dirty_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  // Datapath request and snoop address decode
  logic [IW-1:0] r_idx, s_idx;
  logic [TW-1:0] r_tag, s_tag;
  logic          r_hit, s_hit;
  assign r_idx = cif.dmemaddr[IW+1:2];
  assign r_tag = cif.dmemaddr[31:IW+2];
  assign s_idx = cif.ccsnoopaddr[IW+1:2];
  assign s_tag = cif.ccsnoopaddr[31:IW+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign s_hit = valid_q[s_idx] && (tag_q[s_idx] == s_tag);

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{cif.dmemaddr[1:0], cif.ccsnoopaddr[1:0]};

  // Line update strobes: meta_we writes valid/dirty, line_we writes tag/data
  logic          meta_we, line_we, wr_valid, wr_dirty;
  logic [IW-1:0] wr_idx;
  logic [TW-1:0] wr_tag;
  logic [31:0]   wr_data;

  // Next-state, line updates and output decode; ccwait pre-empts own bus traffic
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    cnt_d    = cnt_q;
    meta_we  = 1'b0;
    line_we  = 1'b0;
    wr_idx   = r_idx;
    wr_valid = 1'b0;
    wr_dirty = 1'b0;
    wr_tag   = r_tag;
    wr_data  = cif.dmemstore;
    cif.dhit     = 1'b0;
    cif.dmemload = '0;
    cif.flushed  = 1'b0;
    cif.dREN     = 1'b0;
    cif.dWEN     = 1'b0;
    cif.daddr    = '0;
    cif.dstore   = '0;
    cif.ccwrite  = 1'b0;
    cif.cctrans  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cif.ccwait) begin
          state_d = SNOOP;
          saved_d = IDLE;
        end else if (cif.dmemREN || cif.dmemWEN) begin
          if (cif.dmemREN && r_hit) begin
            cif.dhit     = 1'b1;
            cif.dmemload = data_q[r_idx];
          end else if (cif.dmemWEN && r_hit && dirty_q[r_idx]) begin
            cif.dhit = 1'b1;
            line_we  = 1'b1;
          end else if (!r_hit && valid_q[r_idx] && dirty_q[r_idx]) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end else if (cif.halt) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      WB: begin
        if (cif.ccwait) begin
          state_d = SNOOP;
          saved_d = WB;
        end else if (!dirty_q[r_idx]) begin
          // a snoop already supplied the victim; nothing left to write back
          state_d = FETCH;
        end else begin
          cif.dWEN   = 1'b1;
          cif.daddr  = {tag_q[r_idx], r_idx, 2'b00};
          cif.dstore = data_q[r_idx];
          if (!cif.dwait) begin
            meta_we  = 1'b1;
            wr_valid = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        if (cif.ccwait) begin
          state_d = SNOOP;
          saved_d = FETCH;
        end else begin
          cif.dREN    = 1'b1;
          cif.cctrans = 1'b1;
          cif.daddr   = cif.dmemaddr;
          cif.ccwrite = cif.dmemWEN;
          if (!cif.dwait) begin
            meta_we  = 1'b1;
            line_we  = 1'b1;
            wr_valid = 1'b1;
            wr_dirty = cif.dmemWEN;
            wr_data  = cif.dmemWEN ? cif.dmemstore : cif.dload;
            state_d  = IDLE;
          end
        end
      end
      SNOOP: begin
        wr_idx = s_idx;
        if (s_hit && dirty_q[s_idx]) begin
          state_d = SNOOP_WB;
        end else begin
          if (cif.ccinv && s_hit) meta_we = 1'b1;
          if (!cif.ccwait) state_d = saved_q;
        end
      end
      SNOOP_WB: begin
        wr_idx     = s_idx;
        cif.dWEN   = 1'b1;
        cif.daddr  = cif.ccsnoopaddr;
        cif.dstore = data_q[s_idx];
        if (!cif.dwait) begin
          meta_we  = 1'b1;
          wr_valid = !cif.ccinv;
          state_d  = SNOOP;
        end
      end
      FLUSH: begin
        wr_idx = cnt_q;
        if (cif.ccwait) begin
          state_d = SNOOP;
          saved_d = FLUSH;
        end else if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
          cif.dWEN   = 1'b1;
          cif.daddr  = {tag_q[cnt_q], cnt_q, 2'b00};
          cif.dstore = data_q[cnt_q];
          if (!cif.dwait) begin
            meta_we  = 1'b1;
            wr_valid = 1'b1;
            if (cnt_q == IW'(SETS - 1)) state_d = DONE;
            else                        cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == IW'(SETS - 1)) state_d = DONE;
          else                        cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    cif.flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Controller state and line MSI bits; reset leaves every line Invalid
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      saved_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      if (meta_we) begin
        valid_q[wr_idx] <= wr_valid;
        dirty_q[wr_idx] <= wr_dirty;
      end
    end
  end

  // Tag/data storage; contents are meaningless while the line is Invalid
  always_ff @(posedge CLK) begin
    if (line_we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end
endmodule

// File: tb/tb_dcache_msi.sv
// Self-checking bench for dcache_msi: vector table, hand-written corner
// sequences, and a randomized run against an address-level reference model.
module tb_dcache_msi;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  dcache_msi_if bus ();
  dcache_msi #(.SETS(16)) dut (.CLK(clk), .nRST(nrst), .cif(bus.master));

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];   // bus-side memory
  logic [31:0] wbq [$];              // bus write addresses observed
  logic [31:0] wbd [$];              // bus write data observed
  int   n_fetch;
  logic fetch_ccw, fetch_cct, fetch_addr_ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.halt = 0; bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = 0; bus.dmemstore = 0;
    bus.dwait = 1; bus.dload = 0; bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1;
  endtask

  // One datapath access with a bus responder of fixed latency. cyc = cycle of dhit.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int lat,
                           output logic [31:0] rd, output int cyc);
    int wc;
    wc = 0; rd = 0; cyc = 0;
    n_fetch = 0; fetch_ccw = 0; fetch_cct = 1; fetch_addr_ok = 1;
    wbq.delete(); wbd.delete();
    bus.dmemREN = r; bus.dmemWEN = w; bus.dmemaddr = a; bus.dmemstore = d;
    forever begin
      bus.dwait = 1; bus.dload = 0;
      #1;
      if (bus.dhit) begin
        rd = bus.dmemload;
        break;
      end
      if (bus.dREN) begin
        n_fetch++;
        fetch_ccw |= bus.ccwrite;
        fetch_cct &= bus.cctrans;
        if (bus.daddr !== a) fetch_addr_ok = 0;
      end
      if (bus.dREN || bus.dWEN) begin
        if (wc < lat) wc++;
        else begin
          wc = 0;
          bus.dwait = 0;
          if (bus.dREN) bus.dload = memrd(bus.daddr);
          if (bus.dWEN) begin
            mem[bus.daddr] = bus.dstore;
            wbq.push_back(bus.daddr);
            wbd.push_back(bus.dstore);
          end
        end
      end
      tick();
      cyc++;
      if (cyc > 300) begin
        chk("access_timeout", 32'(cyc), 0);
        break;
      end
    end
    tick();  // keep the request up across the edge that commits a store hit
    bus.dmemREN = 0; bus.dmemWEN = 0; bus.dwait = 1;
  endtask

  // Snoop of a line expected in M: data must be supplied on the bus.
  task automatic snoop_supply(input logic [31:0] a, input logic inv, input logic [31:0] exp_d);
    logic got;
    got = 0;
    bus.ccwait = 1; bus.ccsnoopaddr = a; bus.ccinv = inv;
    bus.dmemREN = 1; bus.dmemaddr = a;
    #1;
    chk("snoop_no_dhit", 32'(bus.dhit), 0);
    chk("snoop_no_own_bus", 32'({bus.dREN, bus.dWEN}), 0);
    bus.dmemREN = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(); #1;
      got = bus.dWEN;
    end
    chk("snoop_wb_seen", 32'(got), 1);
    chk("snoop_wb_addr", bus.daddr, a);
    chk("snoop_wb_data", bus.dstore, exp_d);
    if (got) mem[bus.daddr] = bus.dstore;
    bus.dwait = 0;
    tick();
    bus.dwait = 1; bus.ccwait = 0; bus.ccinv = 0;
    tick(); tick();
  endtask

  // Halt-driven flush with a zero-latency bus; returns when flushed or out of budget.
  task automatic run_flush();
    wbq.delete(); wbd.delete();
    bus.halt = 1;
    for (int i = 0; i < 200 && !bus.flushed; i++) begin
      bus.dwait = 1; #1;
      if (bus.dWEN) begin
        bus.dwait = 0;
        mem[bus.daddr] = bus.dstore;
        wbq.push_back(bus.daddr);
        wbd.push_back(bus.dstore);
      end
      tick();
    end
    bus.dwait = 1;
    chk("flushed", 32'(bus.flushed), 1);
  endtask

  typedef struct {
    logic        r, w;
    logic [31:0] a, d;
    int          lat;
    logic [31:0] exp_rd;
    int          exp_cyc, exp_fetch, exp_wb;
    logic [31:0] exp_wba;
  } vec_t;

  vec_t        vt [9];
  logic [31:0] rd;
  int          cyc;
  logic [31:0] res_addr [16];
  bit          res_v [16], res_d [16];
  logic [31:0] gold [logic [31:0]];

  initial begin
    idle_inputs();
    vt[0] = '{1, 0, 32'h40,  0,         3, 32'hDEADBEEF, 5, 4, 0, 0};
    vt[1] = '{1, 0, 32'h40,  0,         0, 32'hDEADBEEF, 0, 0, 0, 0};
    vt[2] = '{0, 1, 32'h40,  32'h1234,  1, 0,            3, 2, 0, 0};
    vt[3] = '{0, 1, 32'h40,  32'h5678,  0, 0,            0, 0, 0, 0};
    vt[4] = '{1, 0, 32'h440, 0,         0, 32'h11,       3, 1, 1, 32'h40};
    vt[5] = '{1, 0, 32'h40,  0,         2, 32'h5678,     4, 3, 0, 0};
    vt[6] = '{0, 1, 32'h800, 32'h99,    0, 0,            2, 1, 0, 0};
    vt[7] = '{1, 0, 32'h800, 0,         0, 32'h99,       0, 0, 0, 0};
    vt[8] = '{1, 0, 32'h3C,  0,         0, 32'h5a5a003c, 2, 1, 0, 0};
    mem[32'h40]  = 32'hDEADBEEF;
    mem[32'h440] = 32'h11;

    // Outputs while reset is held
    #2;
    chk("rst_bus_ctl", 32'({bus.dREN, bus.dWEN, bus.ccwrite, bus.cctrans}), 0);
    chk("rst_dp_ctl", 32'({bus.dhit, bus.flushed}), 0);
    chk("rst_daddr", bus.daddr, 0);
    chk("rst_dstore", bus.dstore, 0);
    chk("rst_dmemload", bus.dmemload, 0);
    do_reset();

    // Vector table
    foreach (vt[i]) begin
      do_access(vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].lat, rd, cyc);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].exp_cyc));
      chk($sformatf("vec%0d_fetch_cycles", i), 32'(n_fetch), 32'(vt[i].exp_fetch));
      chk($sformatf("vec%0d_wb_count", i), 32'(wbq.size()), 32'(vt[i].exp_wb));
      if (vt[i].r) chk($sformatf("vec%0d_data", i), rd, vt[i].exp_rd);
      if (vt[i].exp_wb > 0) chk($sformatf("vec%0d_wb_addr", i), wbq[0], vt[i].exp_wba);
      if (n_fetch > 0) begin
        chk($sformatf("vec%0d_ccwrite", i), 32'(fetch_ccw), 32'(vt[i].w));
        chk($sformatf("vec%0d_cctrans", i), 32'(fetch_cct), 1);
        chk($sformatf("vec%0d_fetch_addr", i), 32'(fetch_addr_ok), 1);
      end
    end
    chk("wb_mem_0x40", memrd(32'h40), 32'h5678);

    // Snoop of an M line, no invalidate: supply, line ends S
    do_access(0, 1, 32'h80, 32'hCAFE, 0, rd, cyc);
    snoop_supply(32'h80, 0, 32'hCAFE);
    do_access(1, 0, 32'h80, 0, 0, rd, cyc);
    chk("snoop_s_read_cycles", 32'(cyc), 0);
    chk("snoop_s_read_data", rd, 32'hCAFE);
    // Snoop of an M line with invalidate: supply, line ends I
    do_access(0, 1, 32'h80, 32'hBEEF, 0, rd, cyc);
    chk("store_on_s_cycles", 32'(cyc), 2);
    snoop_supply(32'h80, 1, 32'hBEEF);
    do_access(1, 0, 32'h80, 0, 0, rd, cyc);
    chk("snoop_inv_read_cycles", 32'(cyc), 2);
    chk("snoop_inv_read_data", rd, 32'hBEEF);

    // Snoop landing on a FETCH completion cycle: transfer dropped and retried
    bus.dmemWEN = 1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'h77; bus.dwait = 1;
    tick(); #1;
    chk("fetch_dren", 32'(bus.dREN), 1);
    chk("fetch_daddr", bus.daddr, 32'h100);
    chk("fetch_ccwrite", 32'({bus.ccwrite, bus.cctrans}), 3);
    bus.ccwait = 1; bus.ccsnoopaddr = 32'h200; bus.ccinv = 1; bus.dwait = 0; bus.dload = 32'hBAD;
    #1;
    chk("snoop_drops_dren", 32'(bus.dREN), 0);
    tick(); bus.dwait = 1; #1;
    chk("snoop_state_quiet", 32'({bus.dREN, bus.dWEN, bus.dhit}), 0);
    bus.ccwait = 0; bus.ccinv = 0;
    tick(); #1;
    chk("fetch_resume_dren", 32'(bus.dREN), 1);
    chk("fetch_resume_daddr", bus.daddr, 32'h100);
    chk("fetch_resume_ccwrite", 32'(bus.ccwrite), 1);
    bus.dwait = 0; bus.dload = 32'h1111;
    tick(); bus.dwait = 1; #1;
    chk("fetch_resume_dhit", 32'(bus.dhit), 1);
    tick();
    bus.dmemWEN = 0;
    do_access(1, 0, 32'h100, 0, 0, rd, cyc);
    chk("merged_store_data", rd, 32'h77);

    // Reset during a writeback
    do_access(0, 1, 32'h48, 32'h4242, 0, rd, cyc);
    bus.dmemREN = 1; bus.dmemaddr = 32'h448; bus.dwait = 1;
    tick(); #1;
    chk("wb_dwen", 32'(bus.dWEN), 1);
    chk("wb_daddr", bus.daddr, 32'h48);
    chk("wb_dstore", bus.dstore, 32'h4242);
    nrst = 0;
    #1;
    chk("midrst_ctl", 32'({bus.dREN, bus.dWEN, bus.ccwrite, bus.cctrans, bus.dhit, bus.flushed}), 0);
    chk("midrst_daddr", bus.daddr, 0);
    chk("midrst_dstore", bus.dstore, 0);
    chk("midrst_dmemload", bus.dmemload, 0);
    bus.dmemREN = 0;
    tick();
    nrst = 1;
    tick();
    do_access(1, 0, 32'h48, 0, 0, rd, cyc);
    chk("post_rst_miss_cycles", 32'(cyc), 2);
    chk("post_rst_miss_data", rd, dflt(32'h48));

    // Flush of dirty lines at indices 0, 5, 15; halt together with a request
    do_reset();
    do_access(0, 1, 32'h0,  32'hA0, 0, rd, cyc);
    do_access(0, 1, 32'h14, 32'hA5, 0, rd, cyc);
    do_access(0, 1, 32'h3C, 32'hAF, 0, rd, cyc);
    do_access(1, 0, 32'hC,  0,      0, rd, cyc);
    bus.halt = 1;
    do_access(1, 0, 32'h8, 0, 1, rd, cyc);
    chk("halt_req_cycles", 32'(cyc), 3);
    chk("halt_req_data", rd, dflt(32'h8));
    run_flush();
    chk("flush_wb_count", 32'(wbq.size()), 3);
    if (wbq.size() == 3) begin
      chk("flush_wb0", wbq[0], 32'h0);  chk("flush_wd0", wbd[0], 32'hA0);
      chk("flush_wb1", wbq[1], 32'h14); chk("flush_wd1", wbd[1], 32'hA5);
      chk("flush_wb2", wbq[2], 32'h3C); chk("flush_wd2", wbd[2], 32'hAF);
    end
    bus.dmemREN = 1; bus.dmemaddr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("done_no_dhit", 32'({bus.dhit, bus.dREN, bus.dWEN}), 0);
      chk("done_flushed_sticky", 32'(bus.flushed), 1);
      tick();
    end

    // Randomized accesses against an address-level model
    do_reset();
    mem.delete();
    for (int i = 0; i < 16; i++) begin res_v[i] = 0; res_d[i] = 0; res_addr[i] = 0; end
    for (int n = 0; n < 300; n++) begin
      logic        r, hit, vdirty;
      logic [31:0] a, d, ew;
      int          lat, idx, ec;
      r   = 1'($urandom_range(0, 1));
      a   = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      d   = $urandom;
      lat = $urandom_range(0, 3);
      idx = int'(a[5:2]);
      hit    = res_v[idx] && (res_addr[idx] == a);
      vdirty = res_v[idx] && res_d[idx];
      if (r && hit)                ec = 0;
      else if (!r && hit && vdirty) ec = 0;
      else if (!hit && vdirty)      ec = 2 * lat + 3;
      else                          ec = lat + 2;
      ew = (!hit && vdirty) ? 1 : 0;
      do_access(r, !r, a, d, lat, rd, cyc);
      chk($sformatf("rnd%0d_cycles", n), 32'(cyc), 32'(ec));
      chk($sformatf("rnd%0d_wb_count", n), 32'(wbq.size()), ew);
      if (ew == 1 && wbq.size() == 1) begin
        chk($sformatf("rnd%0d_wb_addr", n), wbq[0], res_addr[idx]);
        chk($sformatf("rnd%0d_wb_data", n), wbd[0], gold[res_addr[idx]]);
      end
      if (r) chk($sformatf("rnd%0d_data", n), rd, gold.exists(a) ? gold[a] : dflt(a));
      if (!r) gold[a] = d;
      res_d[idx]    = !r ? 1'b1 : (hit ? res_d[idx] : 1'b0);
      res_v[idx]    = 1'b1;
      res_addr[idx] = a;
    end
    run_flush();
    foreach (gold[a]) chk($sformatf("rnd_mem_%h", a), memrd(a), gold[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
